// File: rtl/router_pkg.sv
// router_pkg: shared definitions for the router block (FSM, channel FIFOs,
// synchronizer).
//   N_CH_DEF / AW_DEF : default channel count and header address width.
//   state_e           : 4-bit router FSM state encoding.
package router_pkg;

    localparam int N_CH_DEF = 3;
    localparam int AW_DEF   = 2;

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        WAIT_TILL_EMPTY    = 4'd2,
        LOAD_DATA          = 4'd3,
        FIFO_FULL_STATE    = 4'd4,
        LOAD_PARITY        = 4'd5,
        LOAD_AFTER_FULL    = 4'd6,
        CHECK_PARITY_ERROR = 4'd7,
        DROP_PACKET        = 4'd8
    } state_e;

endpackage

// File: rtl/router_fsm_nch_if.sv
// router_fsm_nch_if: control bundle between the router FSM and its
// surroundings (source, channel FIFOs, synchronizer).
//   master : source/FIFO side, drives packet and FIFO status, sees strobes.
//   slave  : FSM side, receives status, drives state strobes, ch_sel, drop_err.
interface router_fsm_nch_if
    import router_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    parameter int AW   = AW_DEF
) ();

    logic            pkt_valid;
    logic [AW-1:0]   data_in;
    logic            fifo_full;
    logic [N_CH-1:0] fifo_empty;
    logic [N_CH-1:0] soft_reset;
    logic            parity_done;
    logic            low_packet_valid;

    logic            detect_add;
    logic            lfd_state;
    logic            ld_state;
    logic            laf_state;
    logic            full_state;
    logic            write_enb_reg;
    logic            reset_int_reg;
    logic            busy;
    logic [AW-1:0]   ch_sel;
    logic            drop_err;

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
               parity_done, low_packet_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, reset_int_reg, busy, ch_sel, drop_err
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
               parity_done, low_packet_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, reset_int_reg, busy, ch_sel, drop_err
    );

endinterface

// File: rtl/router_fsm_nch.sv
// router_fsm_nch: packet router control FSM for N_CH destination channels.
//   clock  : single rising-edge clock.
//   resetn : synchronous active-low reset.
//   bus    : slave side of router_fsm_nch_if (packet/FIFO status in,
//            Moore state strobes, latched ch_sel and drop_err pulse out).
module router_fsm_nch
    import router_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic              clock,
    input  logic              resetn,
    router_fsm_nch_if.slave   bus
);

    // One extra bit so the compare stays meaningful when N_CH == 2**AW.
    localparam logic [AW:0] NCH_LIM = (AW+1)'(N_CH);

    state_e        state_q, state_d;
    logic [AW-1:0] ch_sel_q, ch_sel_d;
    logic          drop_err_q, drop_err_d;
    logic          addr_bad;

    assign addr_bad = ({1'b0, bus.data_in} >= NCH_LIM);

    always_comb begin
        state_d    = state_q;
        ch_sel_d   = ch_sel_q;
        drop_err_d = 1'b0;
        case (state_q)
            DECODE_ADDRESS: begin
                if (bus.pkt_valid) begin
                    if (addr_bad) begin
                        state_d    = DROP_PACKET;
                        // Registered so it is high on the first DROP_PACKET cycle only.
                        drop_err_d = 1'b1;
                    end else begin
                        ch_sel_d = bus.data_in;
                        state_d  = bus.fifo_empty[bus.data_in] ? LOAD_FIRST_DATA
                                                               : WAIT_TILL_EMPTY;
                    end
                end
            end
            LOAD_FIRST_DATA:    state_d = LOAD_DATA;
            WAIT_TILL_EMPTY:    if (bus.fifo_empty[ch_sel_q]) state_d = LOAD_FIRST_DATA;
            LOAD_DATA: begin
                if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
                else if (!bus.pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE:    if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL: begin
                if (bus.parity_done)           state_d = DECODE_ADDRESS;
                else if (bus.low_packet_valid) state_d = LOAD_PARITY;
                else                           state_d = LOAD_DATA;
            end
            LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            DROP_PACKET:        if (!bus.pkt_valid) state_d = DECODE_ADDRESS;
            default:            state_d = DECODE_ADDRESS;
        endcase
        // Soft reset from the selected FIFO aborts an in-flight packet; it has
        // no meaning while idle or while dropping (no channel owned).
        if (state_q != DECODE_ADDRESS && state_q != DROP_PACKET &&
            bus.soft_reset[ch_sel_q])
            state_d = DECODE_ADDRESS;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= DECODE_ADDRESS;
            ch_sel_q   <= '0;
            drop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_sel_q   <= ch_sel_d;
            drop_err_q <= drop_err_d;
        end
    end

    assign bus.detect_add    = (state_q == DECODE_ADDRESS);
    assign bus.lfd_state     = (state_q == LOAD_FIRST_DATA);
    assign bus.ld_state      = (state_q == LOAD_DATA);
    assign bus.laf_state     = (state_q == LOAD_AFTER_FULL);
    assign bus.full_state    = (state_q == FIFO_FULL_STATE);
    assign bus.reset_int_reg = (state_q == CHECK_PARITY_ERROR);
    assign bus.write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                               (state_q == LOAD_AFTER_FULL);
    assign bus.busy          = (state_q == LOAD_FIRST_DATA) || (state_q == WAIT_TILL_EMPTY) ||
                               (state_q == FIFO_FULL_STATE) || (state_q == LOAD_AFTER_FULL) ||
                               (state_q == LOAD_PARITY) || (state_q == CHECK_PARITY_ERROR);
    assign bus.ch_sel        = ch_sel_q;
    assign bus.drop_err      = drop_err_q;

endmodule

// File: tb/tb_router_fsm_nch.sv
// tb_router_fsm_nch: directed bench for router_fsm_nch with N_CH=3 and N_CH=4.
// Each step pushes the expected post-edge outputs to a scoreboard queue, and
// pops/compares after the edge.
module tb_router_fsm_nch;
    import router_pkg::*;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    router_fsm_nch_if #(.N_CH(3), .AW(2)) b3 ();
    router_fsm_nch_if #(.N_CH(4), .AW(2)) b4 ();

    router_fsm_nch #(.N_CH(3), .AW(2)) dut3 (.clock(clock), .resetn(resetn), .bus(b3));
    router_fsm_nch #(.N_CH(4), .AW(2)) dut4 (.clock(clock), .resetn(resetn), .bus(b4));

    typedef struct {
        string       tag;
        logic [10:0] v;   // {strobes[7:0], ch_sel[1:0], drop_err}
    } exp_t;

    exp_t sbq[$];
    int   vecs  = 0;
    int   fails = 0;
    bit   use4  = 1'b0;

    // Strobe order: detect_add, lfd, ld, laf, full, write_enb, reset_int, busy.
    function automatic logic [7:0] strb(input state_e s);
        case (s)
            DECODE_ADDRESS:     return 8'b1000_0000;
            LOAD_FIRST_DATA:    return 8'b0100_0001;
            WAIT_TILL_EMPTY:    return 8'b0000_0001;
            LOAD_DATA:          return 8'b0010_0100;
            FIFO_FULL_STATE:    return 8'b0000_1001;
            LOAD_PARITY:        return 8'b0000_0101;
            LOAD_AFTER_FULL:    return 8'b0001_0101;
            CHECK_PARITY_ERROR: return 8'b0000_0011;
            default:            return 8'b0000_0000;
        endcase
    endfunction

    task automatic step(input string tag, input state_e s, input logic [1:0] ch,
                        input logic drop);
        exp_t        e, g;
        logic [10:0] obs;
        e.tag = tag;
        e.v   = {strb(s), ch, drop};
        sbq.push_back(e);
        @(posedge clock);
        #1;
        g = sbq.pop_front();
        if (use4)
            obs = {b4.detect_add, b4.lfd_state, b4.ld_state, b4.laf_state, b4.full_state,
                   b4.write_enb_reg, b4.reset_int_reg, b4.busy, b4.ch_sel, b4.drop_err};
        else
            obs = {b3.detect_add, b3.lfd_state, b3.ld_state, b3.laf_state, b3.full_state,
                   b3.write_enb_reg, b3.reset_int_reg, b3.busy, b3.ch_sel, b3.drop_err};
        vecs++;
        assert (obs === g.v) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", g.tag, obs, g.v);
        end
    endtask

    initial begin
        resetn = 1'b0;
        b3.pkt_valid = 0; b3.data_in = '0; b3.fifo_full = 0; b3.fifo_empty = '0;
        b3.soft_reset = '0; b3.parity_done = 0; b3.low_packet_valid = 0;
        b4.pkt_valid = 0; b4.data_in = '0; b4.fifo_full = 0; b4.fifo_empty = '0;
        b4.soft_reset = '0; b4.parity_done = 0; b4.low_packet_valid = 0;

        step("reset", DECODE_ADDRESS, 2'd0, 1'b0);
        resetn = 1'b1;

        // Normal packet to channel 1 with empty FIFO.
        b3.pkt_valid = 1; b3.data_in = 2'd1; b3.fifo_empty = 3'b010;
        step("lfd_ch1", LOAD_FIRST_DATA, 2'd1, 1'b0);
        step("ld_ch1", LOAD_DATA, 2'd1, 1'b0);
        b3.pkt_valid = 0;
        step("parity", LOAD_PARITY, 2'd1, 1'b0);
        step("chk_par", CHECK_PARITY_ERROR, 2'd1, 1'b0);
        step("back_decode", DECODE_ADDRESS, 2'd1, 1'b0);

        // Channel 0 busy: wait, data_in ignored while waiting.
        b3.pkt_valid = 1; b3.data_in = 2'd0; b3.fifo_empty = 3'b000;
        step("wait", WAIT_TILL_EMPTY, 2'd0, 1'b0);
        b3.data_in = 2'd3;
        step("wait_ign_data", WAIT_TILL_EMPTY, 2'd0, 1'b0);
        b3.fifo_empty = 3'b001;
        step("wait_to_lfd", LOAD_FIRST_DATA, 2'd0, 1'b0);

        // Full / after-full paths.
        step("ld_ch0", LOAD_DATA, 2'd0, 1'b0);
        b3.fifo_full = 1;
        step("to_full", FIFO_FULL_STATE, 2'd0, 1'b0);
        step("full_stay", FIFO_FULL_STATE, 2'd0, 1'b0);
        b3.fifo_full = 0;
        step("to_laf", LOAD_AFTER_FULL, 2'd0, 1'b0);
        step("laf_to_ld", LOAD_DATA, 2'd0, 1'b0);
        b3.fifo_full = 1;
        step("to_full2", FIFO_FULL_STATE, 2'd0, 1'b0);
        b3.fifo_full = 0;
        step("to_laf2", LOAD_AFTER_FULL, 2'd0, 1'b0);
        b3.low_packet_valid = 1;
        step("laf_to_par", LOAD_PARITY, 2'd0, 1'b0);
        b3.low_packet_valid = 0;
        step("par_to_chk", CHECK_PARITY_ERROR, 2'd0, 1'b0);
        b3.fifo_full = 1;
        step("chk_to_full", FIFO_FULL_STATE, 2'd0, 1'b0);
        b3.fifo_full = 0;
        step("to_laf3", LOAD_AFTER_FULL, 2'd0, 1'b0);
        b3.parity_done = 1;
        step("laf_to_decode", DECODE_ADDRESS, 2'd0, 1'b0);
        b3.parity_done = 0; b3.pkt_valid = 0; b3.soft_reset = 3'b001;
        step("idle_softrst", DECODE_ADDRESS, 2'd0, 1'b0);
        b3.soft_reset = 3'b000;

        // Soft reset on channel 2: other channel ignored, own channel aborts.
        b3.pkt_valid = 1; b3.data_in = 2'd2; b3.fifo_empty = 3'b100;
        step("lfd_ch2", LOAD_FIRST_DATA, 2'd2, 1'b0);
        b3.fifo_full = 1;
        step("lfd_uncond", LOAD_DATA, 2'd2, 1'b0);
        step("full_ch2", FIFO_FULL_STATE, 2'd2, 1'b0);
        b3.soft_reset = 3'b001;
        step("softrst_other", FIFO_FULL_STATE, 2'd2, 1'b0);
        b3.soft_reset = 3'b100;
        step("softrst_own", DECODE_ADDRESS, 2'd2, 1'b0);
        b3.soft_reset = 3'b000; b3.fifo_full = 0; b3.pkt_valid = 0;

        // Out-of-range address: drop, one-cycle drop_err, ch_sel held.
        b3.pkt_valid = 1; b3.data_in = 2'd3;
        step("drop_first", DROP_PACKET, 2'd2, 1'b1);
        b3.soft_reset = 3'b100;
        step("drop_hold", DROP_PACKET, 2'd2, 1'b0);
        b3.soft_reset = 3'b000; b3.pkt_valid = 0;
        step("drop_exit", DECODE_ADDRESS, 2'd2, 1'b0);

        // N_CH=4: every address is legal.
        use4 = 1'b1;
        for (int a = 0; a < 4; a++) begin
            b4.pkt_valid = 1; b4.data_in = 2'(a); b4.fifo_empty = 4'hF;
            step("n4_lfd", LOAD_FIRST_DATA, 2'(a), 1'b0);
            step("n4_ld", LOAD_DATA, 2'(a), 1'b0);
            b4.pkt_valid = 0;
            step("n4_par", LOAD_PARITY, 2'(a), 1'b0);
            step("n4_chk", CHECK_PARITY_ERROR, 2'(a), 1'b0);
            step("n4_dec", DECODE_ADDRESS, 2'(a), 1'b0);
        end
        b4.pkt_valid = 1; b4.data_in = 2'd2;
        step("n4_lfd_r", LOAD_FIRST_DATA, 2'd2, 1'b0);
        step("n4_ld_r", LOAD_DATA, 2'd2, 1'b0);
        resetn = 1'b0;
        step("n4_reset_mid", DECODE_ADDRESS, 2'd0, 1'b0);
        resetn = 1'b1; b4.pkt_valid = 0;
        step("n4_after_rst", DECODE_ADDRESS, 2'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
